// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC plus internal ROM feeding a DEPTH-entry prefetch FIFO
// drained by decode over a valid/ready handshake. A redirect flushes the FIFO
// and refills it with the target entry.
// Optional feature macro: FETCH_JAL_PREDECODE_EN. When it is defined, a JAL
// pushed into the FIFO steers the fetch PC to the jump target and is marked
// with Pred_D. When it is undefined, fetch is always sequential and Pred_D
// is tied to 0.
// The ROM contents are loaded by the surrounding environment.
module fetch_queue #(
  parameter int unsigned     XLEN       = 64,
  parameter int unsigned     ILEN       = 32,
  parameter int unsigned     DEPTH      = 4,
  parameter int unsigned     IMEM_WORDS = 1024,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PCWrite_F,
  input  logic [XLEN-1:0]        PCTarget,
  input  logic                   Ready_D,
  output logic                   Valid_D,
  output logic [XLEN-1:0]        PC_D,
  output logic [ILEN-1:0]        Instr_D,
  output logic                   Pred_D,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = $clog2(IMEM_WORDS);
  localparam logic [6:0]  OPC_JAL = 7'b1101111;

  // Instruction ROM, read combinationally
  logic [ILEN-1:0] rom [IMEM_WORDS];

  // FIFO storage
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [ILEN-1:0] q_instr [DEPTH];

  // Control state
  logic [XLEN-1:0] pc, pc_nxt;
  logic [PW-1:0]   rd_ptr, rd_ptr_nxt;
  logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
  logic [CW-1:0]   count, count_nxt;

  // Write port into the FIFO
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [XLEN-1:0] wr_pc;
  logic [ILEN-1:0] wr_instr;

  // Fetch datapath
  logic [XLEN-1:0] tgt;
  logic [ILEN-1:0] fetch_word;
  logic [ILEN-1:0] tgt_word;
  logic [XLEN-1:0] fetch_step;
  logic [XLEN-1:0] tgt_step;
  logic            pop;
  logic            push;
  logic            head_valid;

`ifdef FETCH_JAL_PREDECODE_EN
  logic [DEPTH-1:0] q_pred;
  logic             wr_pred;
  logic             fetch_jal;
  logic             tgt_jal;
`endif

  // Redirect address low bits are ignored
  logic unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^PCTarget[1:0];

  assign head_valid = (count != '0);

  // ROM lookups and PC increments for the sequential and redirect paths
  always_comb begin
    tgt        = {PCTarget[XLEN-1:2], 2'b00};
    fetch_word = rom[pc[AW+1:2]];
    tgt_word   = rom[tgt[AW+1:2]];
    fetch_step = XLEN'(4);
    tgt_step   = XLEN'(4);
`ifdef FETCH_JAL_PREDECODE_EN
    fetch_jal  = (fetch_word[6:0] == OPC_JAL);
    tgt_jal    = (tgt_word[6:0] == OPC_JAL);
    if (fetch_jal) begin
      fetch_step = {{(XLEN-21){fetch_word[31]}}, fetch_word[31], fetch_word[19:12],
                    fetch_word[20], fetch_word[30:21], 1'b0};
    end
    if (tgt_jal) begin
      tgt_step = {{(XLEN-21){tgt_word[31]}}, tgt_word[31], tgt_word[19:12],
                  tgt_word[20], tgt_word[30:21], 1'b0};
    end
`endif
  end

  // Next-state: redirect flushes and refills with one entry, else push/pop
  always_comb begin
    pc_nxt     = pc;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    pop        = 1'b0;
    push       = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = wr_ptr;
    wr_pc      = pc;
    wr_instr   = fetch_word;
`ifdef FETCH_JAL_PREDECODE_EN
    wr_pred    = fetch_jal;
`endif
    if (PCWrite_F) begin
      // Everything in flight is squashed, including a head decode is taking now
      wr_en      = 1'b1;
      wr_idx     = '0;
      wr_pc      = tgt;
      wr_instr   = tgt_word;
`ifdef FETCH_JAL_PREDECODE_EN
      wr_pred    = tgt_jal;
`endif
      pc_nxt     = tgt + tgt_step;
      rd_ptr_nxt = '0;
      wr_ptr_nxt = PW'(1);
      count_nxt  = CW'(1);
    end else begin
      pop  = head_valid && Ready_D;
      // A full FIFO still accepts a push when the head leaves in the same cycle
      push = (count != CW'(DEPTH)) || pop;
      if (pop) begin
        rd_ptr_nxt = rd_ptr + PW'(1);
      end
      if (push) begin
        wr_en      = 1'b1;
        wr_ptr_nxt = wr_ptr + PW'(1);
        pc_nxt     = pc + fetch_step;
      end
      count_nxt = count + CW'(push) - CW'(pop);
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      pc     <= pc_nxt;
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Entry storage; stale slots are harmless since only counted entries are visible
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      q_pc[wr_idx]    <= wr_pc;
      q_instr[wr_idx] <= wr_instr;
`ifdef FETCH_JAL_PREDECODE_EN
      q_pred[wr_idx]  <= wr_pred;
`endif
    end
  end

  // Head outputs straight from storage, zero while empty
  always_comb begin
    Valid_D = head_valid;
    PC_D    = '0;
    Instr_D = '0;
    Pred_D  = 1'b0;
    if (head_valid) begin
      PC_D    = q_pc[rd_ptr];
      Instr_D = q_instr[rd_ptr];
`ifdef FETCH_JAL_PREDECODE_EN
      Pred_D  = q_pred[rd_ptr];
`endif
    end
  end

  assign Count = count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios followed by a randomized run, all checked
// against a queue-based reference model of the fetch queue.
module tb_fetch_queue;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned ILEN       = 32;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned IMEM_WORDS = 1024;
  localparam logic [63:0] RESET_PC   = 64'h0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        pred;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite_F;
  logic [63:0] PCTarget;
  logic        Ready_D;
  logic        Valid_D;
  logic [63:0] PC_D;
  logic [31:0] Instr_D;
  logic        Pred_D;
  logic [2:0]  Count;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] img [IMEM_WORDS];
  ent_t        mq [$];
  logic [63:0] mpc;

  fetch_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH),
    .IMEM_WORDS(IMEM_WORDS), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .PCWrite_F(PCWrite_F), .PCTarget(PCTarget),
    .Ready_D(Ready_D), .Valid_D(Valid_D), .PC_D(PC_D), .Instr_D(Instr_D),
    .Pred_D(Pred_D), .Count(Count)
  );

  always #5 clk = ~clk;

  function automatic ent_t fetch_at(input logic [63:0] a);
    ent_t e;
    e.pc    = a;
    e.instr = img[(a >> 2) % IMEM_WORDS];
`ifdef FETCH_JAL_PREDECODE_EN
    e.pred  = (e.instr[6:0] == 7'h6F);
`else
    e.pred  = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [63:0] after(input ent_t e);
    logic [63:0] imm;
    if (e.pred) begin
      imm = {{43{e.instr[31]}}, e.instr[31], e.instr[19:12], e.instr[20], e.instr[30:21], 1'b0};
      return e.pc + imm;
    end
    return e.pc + 64'd4;
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic [63:0] t, input logic rd);
    ent_t e;
    logic popd;
    logic pushd;
    if (r) begin
      mq.delete();
      mpc = RESET_PC;
    end else if (w) begin
      e = fetch_at({t[63:2], 2'b00});
      mq.delete();
      mq.push_back(e);
      mpc = after(e);
    end else begin
      popd  = (mq.size() != 0) && rd;
      pushd = (mq.size() < DEPTH) || popd;
      if (popd) void'(mq.pop_front());
      if (pushd) begin
        e = fetch_at(mpc);
        mq.push_back(e);
        mpc = after(e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    ent_t h;
    h.pc = '0; h.instr = '0; h.pred = 1'b0;
    if (mq.size() != 0) h = mq[0];
    chk("valid", 64'(Valid_D), 64'(mq.size() != 0));
    chk("count", 64'(Count), 64'(mq.size()));
    chk("pc_d", PC_D, h.pc);
    chk("instr_d", 64'(Instr_D), 64'(h.instr));
    chk("pred_d", 64'(Pred_D), 64'(h.pred));
  endtask

  task automatic step(input logic r, input logic w, input logic [63:0] t, input logic rd);
    rst = r; PCWrite_F = w; PCTarget = t; Ready_D = rd;
    @(posedge clk);
    model_edge(r, w, t, rd);
    @(negedge clk);
    check_model();
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    img[idx] = v;
    dut.rom[idx] = v;
  endtask

  initial begin
    rst = 1'b1; PCWrite_F = 1'b0; PCTarget = '0; Ready_D = 1'b0;
    mpc = RESET_PC;
    for (int i = 0; i < IMEM_WORDS; i++) begin
      img[i] = $urandom;
      if ($urandom_range(7) == 0) img[i][6:0] = 7'h6F;
    end
    img[0] = 32'h00000013; img[1] = 32'h00500093; img[2] = 32'h00000013;
    img[3] = 32'h00000013; img[4] = 32'h00000013; img[10] = 32'hDEADBEEF;
    for (int i = 0; i < IMEM_WORDS; i++) dut.rom[i] = img[i];

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("rst_valid", 64'(Valid_D), 64'd0);
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_pc_d", PC_D, 64'd0);

    // First fetches stream out one per cycle
    step(0, 0, 0, 1);
    chk("t1_pc0", PC_D, 64'h0);
    chk("t1_in0", 64'(Instr_D), 64'h00000013);
    step(0, 0, 0, 1);
    chk("t1_pc1", PC_D, 64'h4);
    chk("t1_in1", 64'(Instr_D), 64'h00500093);
    step(0, 0, 0, 1);
    chk("t1_pc2", PC_D, 64'h8);
    chk("t1_in2", 64'(Instr_D), 64'h00000013);

    // Saturate with decode stalled, then drain in order
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    chk("t2_full_cnt", 64'(Count), 64'd4);
    chk("t2_full_pc", PC_D, 64'h0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 1);
      chk("t2_drain_pc", PC_D, 64'(4 * k));
    end

    // Redirect while three entries are queued
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("t3_cnt3", 64'(Count), 64'd3);
    step(0, 1, 64'h2B, 0);
    chk("t3_valid", 64'(Valid_D), 64'd1);
    chk("t3_pc", PC_D, 64'h28);
    chk("t3_instr", 64'(Instr_D), 64'hDEADBEEF);
    chk("t3_cnt", 64'(Count), 64'd1);

    // Redirect during a pop, then reset mid-stream
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 64'h40, 1);
    chk("t4_pc", PC_D, 64'h40);
    chk("t4_cnt", 64'(Count), 64'd1);
    step(1, 0, 0, 1);
    chk("t4_rst_valid", 64'(Valid_D), 64'd0);
    chk("t4_rst_cnt", 64'(Count), 64'd0);
    step(0, 0, 0, 1);
    chk("t4_refetch", PC_D, RESET_PC);

    // Index wrap on a high redirect target
    step(0, 1, 64'h1000, 0);
    chk("t5_pc", PC_D, 64'h1000);
    chk("t5_instr", 64'(Instr_D), 64'h00000013);

    // JAL in the stream
    set_word(1, 32'h0100006F);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("t6_pc0", PC_D, 64'h0);
    step(0, 0, 0, 1);
    chk("t6_pc1", PC_D, 64'h4);
`ifdef FETCH_JAL_PREDECODE_EN
    chk("t6_pred", 64'(Pred_D), 64'd1);
    step(0, 0, 0, 1);
    chk("t6_pc2", PC_D, 64'h14);
`else
    chk("t6_pred", 64'(Pred_D), 64'd0);
    step(0, 0, 0, 1);
    chk("t6_pc2", PC_D, 64'h8);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic        r;
      logic        w;
      logic [63:0] t;
      logic        rd;
      r  = ($urandom_range(49) == 0);
      w  = ($urandom_range(7) == 0);
      t  = {$urandom, $urandom};
      if ($urandom_range(1) == 0) t = 64'($urandom_range(8191));
      rd = ($urandom_range(3) != 0);
      step(r, w, t, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
